spi_tx_word_scheduler: RTL and testbench

- Shares the slave-SPI transmit byte stream between NREQ word-wide NITTA sources.
- Arbitrates round-robin and latches the granted DATA_WIDTH word.
- Drives it to the SPI slave driver one SPI_DATA_WIDTH chunk per driver `prepare` pulse, MSB chunk first.
- Sits between the NITTA processor-unit outputs and the slave SPI driver; replaces the fixed single-source word-to-SPI splitting path.

---
 rtl/spi_tx_sched_pkg.sv | 31 +++
 rtl/spi_tx_word_scheduler_if.sv | 37 +++
 rtl/spi_tx_sched_rr_arbiter.sv | 37 +++
 rtl/spi_tx_word_scheduler.sv | 149 ++++++++++++++
 tb/tb_spi_tx_word_scheduler.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_tx_sched_pkg.sv
// Shared types and helpers for the SPI transmit word scheduler.
//   state_e        : scheduler FSM states (idle / sending a word)
//   UnderrunWidth  : width of the saturating underrun counter
//   clog2()        : index width helper, never narrower than 1 bit
//   chunks()       : number of SPI chunks per requester word
package spi_tx_sched_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    localparam int unsigned UnderrunWidth = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned chunks(input int unsigned data_width,
                                           input int unsigned spi_width);
        return data_width / spi_width;
    endfunction

endpackage

// File: rtl/spi_tx_word_scheduler_if.sv
// Bus bundle between the word requesters / SPI slave driver and the scheduler.
//   req, data_in        : per-requester level request and flattened words
//   grant               : one-hot pulse, word of requester i latched
//   spi_prepare, cs     : driver chunk-consumed pulse, filtered chip select (active-low)
//   to_spi              : registered chunk to the driver
//   busy, word_done     : word in flight, last chunk consumed pulse
//   underrun            : saturating count of prepare pulses with no word
// Modports: master = requesters/driver side, slave = scheduler.
interface spi_tx_word_scheduler_if
    import spi_tx_sched_pkg::*;
#(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SPI_DATA_WIDTH = 8
);

    logic [NREQ-1:0]            req;
    logic [NREQ*DATA_WIDTH-1:0] data_in;
    logic [NREQ-1:0]            grant;
    logic                       spi_prepare;
    logic                       cs;
    logic [SPI_DATA_WIDTH-1:0]  to_spi;
    logic                       busy;
    logic                       word_done;
    logic [UnderrunWidth-1:0]   underrun;

    modport master (
        output req, data_in, spi_prepare, cs,
        input  grant, to_spi, busy, word_done, underrun
    );

    modport slave (
        input  req, data_in, spi_prepare, cs,
        output grant, to_spi, busy, word_done, underrun
    );

endinterface

// File: rtl/spi_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting index at or
// after ptr, wrapping around.
//   req  : request vector
//   ptr  : highest-priority index
//   gnt  : one-hot winner
//   idx  : encoded winner
//   any  : at least one request present
module spi_tx_sched_rr_arbiter
    import spi_tx_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    localparam int unsigned PtrW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PtrW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PtrW-1:0] idx,
    output logic            any
);

    always_comb begin
        int unsigned sel;
        sel = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sel = (32'(ptr) + k) % NREQ;
            if (!any && req[sel]) begin
                any      = 1'b1;
                idx      = PtrW'(sel);
                gnt[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_tx_word_scheduler.sv
// Shares the slave-SPI transmit byte stream between NREQ word-wide sources.
// A round-robin winner's word is latched and presented to the SPI driver one
// SPI_DATA_WIDTH chunk per prepare pulse, MSB chunk first. A cs rising edge
// mid-word rewinds to the MSB chunk so the word is replayed in the next frame.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : spi_tx_word_scheduler_if.slave (req/data_in/grant, prepare/cs,
//              to_spi, busy, word_done, underrun)
// Build option: SPI_TX_SCHED_UNDERRUN_EN builds the underrun counter;
// otherwise underrun is tied to 0.
module spi_tx_word_scheduler
    import spi_tx_sched_pkg::*;
#(
    parameter int unsigned SPI_DATA_WIDTH = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NREQ           = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_tx_word_scheduler_if.slave  bus
);

    localparam int unsigned Chunks    = chunks(DATA_WIDTH, SPI_DATA_WIDTH);
    localparam int unsigned ChunkIdxW = clog2(Chunks);
    localparam int unsigned PtrW      = clog2(NREQ);

    state_e                    state_q, state_d;
    logic [ChunkIdxW-1:0]      idx_q, idx_d;
    logic [PtrW-1:0]           ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]     word_q, word_d;
    logic [SPI_DATA_WIDTH-1:0] to_spi_q, to_spi_d;
    logic [NREQ-1:0]           grant_q, grant_d;
    logic                      busy_q, busy_d;
    logic                      word_done_q, word_done_d;
    logic                      cs_q;

    logic [NREQ-1:0]           arb_gnt;
    logic [PtrW-1:0]           arb_idx;
    logic                      arb_any;
    logic [DATA_WIDTH-1:0]     arb_word;
    logic                      cs_rise;

    // Chunk k counted from the MSB end of the word.
    function automatic logic [SPI_DATA_WIDTH-1:0] chunk_of(input logic [DATA_WIDTH-1:0] word,
                                                          input int unsigned k);
        return word[(Chunks-1-k)*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
    endfunction

    spi_tx_sched_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arbiter (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign arb_word = bus.data_in[32'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign cs_rise  = bus.cs & ~cs_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        word_d      = word_q;
        to_spi_d    = to_spi_q;
        busy_d      = busy_q;
        grant_d     = '0;
        word_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                to_spi_d = '0;
                if (arb_any) begin
                    grant_d  = arb_gnt;
                    word_d   = arb_word;
                    idx_d    = '0;
                    to_spi_d = chunk_of(arb_word, 0);
                    busy_d   = 1'b1;
                    ptr_d    = (arb_idx == PtrW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
                    state_d  = StSend;
                end
            end
            StSend: begin
                // Frame abort outranks a coincident prepare.
                if (cs_rise && idx_q != '0) begin
                    idx_d    = '0;
                    to_spi_d = chunk_of(word_q, 0);
                end else if (bus.spi_prepare) begin
                    if (idx_q == ChunkIdxW'(Chunks-1)) begin
                        word_done_d = 1'b1;
                        busy_d      = 1'b0;
                        to_spi_d    = '0;
                        state_d     = StIdle;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        to_spi_d = chunk_of(word_q, 32'(idx_q) + 1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            ptr_q       <= '0;
            word_q      <= '0;
            to_spi_q    <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
            cs_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            word_q      <= word_d;
            to_spi_q    <= to_spi_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
            cs_q        <= bus.cs;
        end
    end

`ifdef SPI_TX_SCHED_UNDERRUN_EN
    logic [UnderrunWidth-1:0] underrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_q <= '0;
        end else if (state_q == StIdle && bus.spi_prepare && underrun_q != '1) begin
            underrun_q <= underrun_q + 1'b1;
        end
    end

    assign bus.underrun = underrun_q;
`else
    assign bus.underrun = '0;
`endif

    assign bus.grant     = grant_q;
    assign bus.to_spi    = to_spi_q;
    assign bus.busy      = busy_q;
    assign bus.word_done = word_done_q;

endmodule

// File: tb/tb_spi_tx_word_scheduler.sv
module tb_spi_tx_word_scheduler;

    logic clk;
    logic rst;
    int   tests;
    int   errors;
    int   grant_cnt;
    int   done_cnt;

`ifdef SPI_TX_SCHED_UNDERRUN_EN
    localparam int unsigned ExpUnderrun = 3;
`else
    localparam int unsigned ExpUnderrun = 0;
`endif

    spi_tx_word_scheduler_if #(
        .NREQ           (2),
        .DATA_WIDTH     (32),
        .SPI_DATA_WIDTH (8)
    ) bus ();

    spi_tx_word_scheduler #(
        .SPI_DATA_WIDTH (8),
        .DATA_WIDTH     (32),
        .NREQ           (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.grant != 2'b00) grant_cnt++;
        if (bus.word_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; outputs sampled afterwards reflect the prepare.
    task automatic pulse_prepare();
        bus.spi_prepare = 1'b1;
        @(negedge clk);
        bus.spi_prepare = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        bus.req         = '0;
        bus.spi_prepare = 1'b0;
        bus.cs          = 1'b1;
        @(negedge clk);
        rst       = 1'b1;
        grant_cnt = 0;
        done_cnt  = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rr_bytes [8];
        rr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        tests = 0; errors = 0; grant_cnt = 0; done_cnt = 0;
        rst = 1'b0;
        bus.req = '0; bus.data_in = '0; bus.spi_prepare = 1'b0; bus.cs = 1'b1;
        #12;
        check("rst_to_spi", 32'(bus.to_spi), 32'h0);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_word_done", 32'(bus.word_done), 32'h0);
        check("rst_underrun", 32'(bus.underrun), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single word, prepares spaced 100 cycles apart
        bus.cs = 1'b0;
        bus.data_in = {32'h0, 32'hAAABACAD};
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        check("single_grant", 32'(bus.grant), 32'h1);
        check("single_busy", 32'(bus.busy), 32'h1);
        check("single_b0", 32'(bus.to_spi), 32'hAA);
        for (int i = 0; i < 4; i++) begin
            repeat (100) @(negedge clk);
            pulse_prepare();
            if (i < 3) check("single_chunk", 32'(bus.to_spi), 32'(8'hAB + i));
        end
        check("single_done", 32'(bus.word_done), 32'h1);
        check("single_idle_to_spi", 32'(bus.to_spi), 32'h0);
        check("single_idle_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        check("single_done_pulse", 32'(bus.word_done), 32'h0);

        // Round-robin with both requests held
        do_reset();
        bus.cs = 1'b0;
        bus.data_in = {32'h55667788, 32'h11223344};
        bus.req = 2'b11;
        @(negedge clk);
        check("rr_grant0", 32'(bus.grant), 32'h1);
        for (int i = 0; i < 8; i++) begin
            check("rr_byte", 32'(bus.to_spi), 32'(rr_bytes[i]));
            pulse_prepare();
            if (i == 3) begin
                check("rr_done0", 32'(bus.word_done), 32'h1);
                @(negedge clk);
                check("rr_grant1", 32'(bus.grant), 32'h2);
            end
        end
        check("rr_done1", 32'(bus.word_done), 32'h1);
        @(negedge clk);
        check("rr_grant2", 32'(bus.grant), 32'h1);
        bus.req = 2'b00;

        // Abort / replay after two prepares
        do_reset();
        bus.cs = 1'b0;
        bus.data_in = {32'h0, 32'hAAABACAD};
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        pulse_prepare();
        pulse_prepare();
        check("abort_pre", 32'(bus.to_spi), 32'hAC);
        bus.cs = 1'b1;
        @(negedge clk);
        check("abort_replay", 32'(bus.to_spi), 32'hAA);
        check("abort_busy", 32'(bus.busy), 32'h1);
        bus.cs = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_b0", 32'(bus.to_spi), 32'hAA);
        for (int i = 0; i < 3; i++) begin
            pulse_prepare();
            check("abort_chunk", 32'(bus.to_spi), 32'(8'hAB + i));
        end
        pulse_prepare();
        check("abort_done", 32'(bus.word_done), 32'h1);
        @(negedge clk);
        check("abort_grants", 32'(grant_cnt), 32'd1);
        check("abort_dones", 32'(done_cnt), 32'd1);

        // cs rising edge and prepare in the same cycle at idx=1
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        pulse_prepare();
        check("simul_pre", 32'(bus.to_spi), 32'hAB);
        bus.cs = 1'b1;
        pulse_prepare();
        check("simul_replay", 32'(bus.to_spi), 32'hAA);
        check("simul_busy", 32'(bus.busy), 32'h1);
        check("simul_no_done", 32'(bus.word_done), 32'h0);

        // Underrun: prepares with no word
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse_prepare();
            check("underrun_to_spi", 32'(bus.to_spi), 32'h0);
        end
        check("underrun_count", 32'(bus.underrun), 32'(ExpUnderrun));
        check("underrun_busy", 32'(bus.busy), 32'h0);

        // Asynchronous reset mid-word
        do_reset();
        bus.cs = 1'b0;
        bus.data_in = {32'hCAFEBABE, 32'hAAABACAD};
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        pulse_prepare();
        check("arst_pre", 32'(bus.to_spi), 32'hAB);
        #2 rst = 1'b0;
        #1;
        check("arst_to_spi", 32'(bus.to_spi), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_grant", 32'(bus.grant), 32'h0);
        check("arst_underrun", 32'(bus.underrun), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        grant_cnt = 0;
        bus.req = 2'b10;
        @(negedge clk);
        bus.req = 2'b00;
        check("arst_grant1", 32'(bus.grant), 32'h2);
        check("arst_b0", 32'(bus.to_spi), 32'hCA);
        pulse_prepare();
        check("arst_b1", 32'(bus.to_spi), 32'hFE);
        pulse_prepare();
        check("arst_b2", 32'(bus.to_spi), 32'hBA);
        pulse_prepare();
        check("arst_b3", 32'(bus.to_spi), 32'hBE);
        pulse_prepare();
        check("arst_done", 32'(bus.word_done), 32'h1);
        @(negedge clk);
        check("arst_dones", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
